sub_packetreq_ring: RTL and testbench
=====================================

// Module: sub_packetreq_ring
// PURPOSE
//  Single-clock, NSLOTS-deep ring of request-packet buffers between the MAC RX byte interface and the IPbus transactor.
//  - Pulls each frame byte-wise (rxa/rxd), packs bytes into 32-bit words and computes the payload word length.
//  - Presents the oldest complete packet for word-addressed reads until the consumer releases it.
//  - Successor to the two-half ping-pong buffer: adds depth, a runt-drop check, occupancy and a drop counter.
// PARAMETERS
//  NSLOTS     4   packet slots; power of 2, >=2
//  ADDR_W     11  RX byte-address width; slot = 2^(ADDR_W-2) words
//  HDR_BYTES  14  link header bytes stripped before the length computation
//  HDR_WORDS  7   IP/UDP/IPbus header words subtracted from the length
//  CNT_W      16  drop counter width
// PORTS
//  mac_clk           in   1             sole clock
//  reset_n           in   1             asynchronous, active-low reset
//  incoming_ready    in   1             RX frame present; held high until copydone is seen
//  rxl               in   ADDR_W        byte address of the last frame byte (frame = rxl+1 bytes)
//  rxa               out  ADDR_W        RX byte read address
//  rxd               in   8             byte at rxa, valid 1 cycle after rxa
//  copydone          out  1             frame consumed; RX side may drop incoming_ready
//  done_with_packet  in   1             1-cycle pulse: release head slot
//  packet_avail      out  1             occupancy != 0
//  busy              out  1             occupancy == NSLOTS
//  read_addr         in   ADDR_W-2      word address within head slot
//  read_data         out  32            word at {rd_ptr,read_addr}, 1-cycle latency
//  len               out  ADDR_W-2      payload words of head slot; 0 when empty
//  occupancy         out  $clog2(NSLOTS)+1  full slots
//  drop_count        out  CNT_W         runt frames discarded; saturating
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; rxa, wr_ptr, rd_ptr, occupancy and drop_count = 0;
//   copydone, packet_avail and busy = 0; all slot lengths = 0. Reset mid-copy discards the partial frame.
//  FSM:
//   IDLE  -> COPY when incoming_ready && !busy; rxa<=0. While busy, stay in IDLE; upstream holds the frame.
//   COPY  -> rxa increments by 1 each cycle. The byte fetched at rxa is written 1 cycle later at rxa_d.
//            When rxa==rxl, go to DONE.
//   DONE  -> copydone=1; the first cycle writes the final byte. Wait for !incoming_ready, then commit and go to IDLE.
//  Packing: byte address a -> word a[ADDR_W-1:2], lane 3-a[1:0], so byte 0 lands in [31:24] (network order).
//   Byte-enable write; lanes beyond rxl keep stale data.
//  Length: L = ((rxl+1-HDR_BYTES)>>2) - HDR_WORDS, computed at ADDR_W+1 bits signed.
//   L<=0 (runt): commit drops the frame; drop_count+1 (saturates at all-ones); pointers unchanged.
//   Otherwise: slot_len[wr_ptr]<=L[ADDR_W-3:0], wr_ptr+1 (mod NSLOTS), occupancy+1.
//  done_with_packet with occupancy==0: ignored. Otherwise rd_ptr+1 and occupancy-1.
//  Same-cycle commit and release: both pointers advance; occupancy unchanged.
//  len and packet_avail update the cycle after a commit or release.
//   read_data reflects the new head from the 2nd cycle after release.
//  Frames with rxl >= 2^ADDR_W are impossible by width. No wrap into the next slot: slot index is the address MSBs.
// STRUCTURE
//  Package ipbus_pkt_pkg: FSM state encoding (IDLE/COPY/DONE) and function pkt_len(rxl) implementing L.
//  Sub-module sub_packetreq_ram: simple dual-port RAM, NSLOTS*2^(ADDR_W-2) x 32.
//   Write port: 4-bit byte enable. Read port: registered.
//  Top level holds the FSM, pointers, slot_len array and counters.
// TESTING
//  1. 78-byte frame (rxl=77), ring empty -> copydone after 79 cycles; packet_avail=1; len=9;
//     word0 = {b0,b1,b2,b3}.
//  2. 5 valid frames, no release, NSLOTS=4 -> busy=1 after the 4th. 5th held in IDLE (rxa static).
//     One done_with_packet -> 5th accepted; occupancy returns to 4.
//  3. Runt frame rxl=40 (L=-1) -> drop_count=1; occupancy unchanged; rxa returns to idle.
//  4. done_with_packet in the same cycle as commit at occupancy=2 -> occupancy stays 2;
//     len switches to the next slot's length.
//  5. reset_n low mid-COPY at rxa=20 -> all outputs 0 immediately. After release, a new frame copies into slot 0.
//  6. Wrap: 2*NSLOTS+1 frames with interleaved releases and distinct payloads ->
//     each read back in order with correct len; the pointers wrap.

Source files
------------

// File: rtl/ipbus_pkt_pkg.sv
// Shared definitions for the request-packet ring: FSM encoding and the
// payload-length formula applied to each received frame.
package ipbus_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COPY = 2'd1,
    ST_DONE = 2'd2
  } pkt_state_t;

  // Arithmetic shift keeps very short frames negative so they are treated as runts.
  function automatic int pkt_len(input int rxl, input int hdr_bytes, input int hdr_words);
    return ((rxl + 32'sd1 - hdr_bytes) >>> 2) - hdr_words;
  endfunction

endpackage

// File: rtl/sub_packetreq_ram.sv
// Simple dual-port packet RAM: byte-enabled write port, registered read port.
module sub_packetreq_ram #(
  parameter int AW = 11
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];
  logic [31:0] r_rdata;

  // Byte-lane write; lanes with a clear enable keep their stale contents
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) begin
          r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read; the output register clears on reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= 32'd0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sub_packetreq_ring.sv
// NSLOTS-deep ring of request-packet buffers: copies frames byte-wise from the
// MAC RX port into word slots and serves the oldest complete packet to IPbus.
module sub_packetreq_ring
  import ipbus_pkt_pkg::*;
#(
  parameter int NSLOTS    = 4,
  parameter int ADDR_W    = 11,
  parameter int HDR_BYTES = 14,
  parameter int HDR_WORDS = 7,
  parameter int CNT_W     = 16
) (
  input  logic                      mac_clk,
  input  logic                      reset_n,
  input  logic                      incoming_ready,
  input  logic [ADDR_W-1:0]         rxl,
  output logic [ADDR_W-1:0]         rxa,
  input  logic [7:0]                rxd,
  output logic                      copydone,
  input  logic                      done_with_packet,
  output logic                      packet_avail,
  output logic                      busy,
  input  logic [ADDR_W-3:0]         read_addr,
  output logic [31:0]               read_data,
  output logic [ADDR_W-3:0]         len,
  output logic [$clog2(NSLOTS):0]   occupancy,
  output logic [CNT_W-1:0]          drop_count
);

  localparam int PTR_W = $clog2(NSLOTS);
  localparam int OCC_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;
  localparam int LEN_W = ADDR_W + 1;

  pkt_state_t               r_state;
  logic [ADDR_W-1:0]        r_rxa;
  logic [ADDR_W-1:0]        r_rxa_d;
  logic                     r_wr_vld;
  logic                     r_copydone;
  logic signed [LEN_W-1:0]  r_pkt_len;
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [OCC_W-1:0]         r_occ;
  logic                     r_avail;
  logic                     r_busy;
  logic [WA_W-1:0]          r_len;
  logic [CNT_W-1:0]         r_drop;
  logic [WA_W-1:0]          r_slot_len [NSLOTS];

  logic                     w_commit;
  logic                     w_runt;
  logic                     w_keep;
  logic                     w_drop;
  logic                     w_release;
  logic [WA_W-1:0]          w_new_len;
  logic [PTR_W-1:0]         w_wr_ptr_n;
  logic [PTR_W-1:0]         w_rd_ptr_n;
  logic [OCC_W-1:0]         w_occ_n;
  logic [WA_W-1:0]          w_head_len;
  logic [1:0]               w_lane;
  logic [3:0]               w_be;
  logic [PTR_W+WA_W-1:0]    w_wr_addr;
  logic [PTR_W+WA_W-1:0]    w_rd_addr;

  assign w_commit  = (r_state == ST_DONE) && !incoming_ready;
  assign w_runt    = r_pkt_len[LEN_W-1] || (r_pkt_len == {LEN_W{1'b0}});
  assign w_keep    = w_commit && !w_runt;
  assign w_drop    = w_commit && w_runt;
  assign w_release = done_with_packet && (r_occ != {OCC_W{1'b0}});
  assign w_new_len = r_pkt_len[WA_W-1:0];

  // Next-state of the ring bookkeeping and the length of the head-to-be
  always_comb begin
    w_wr_ptr_n = r_wr_ptr;
    w_rd_ptr_n = r_rd_ptr;
    w_occ_n    = r_occ;
    w_head_len = {WA_W{1'b0}};
    if (w_keep) begin
      w_wr_ptr_n = r_wr_ptr + PTR_W'(1);
    end else begin
      w_wr_ptr_n = r_wr_ptr;
    end
    if (w_release) begin
      w_rd_ptr_n = r_rd_ptr + PTR_W'(1);
    end else begin
      w_rd_ptr_n = r_rd_ptr;
    end
    case ({w_keep, w_release})
      2'b10:   w_occ_n = r_occ + OCC_W'(1);
      2'b01:   w_occ_n = r_occ - OCC_W'(1);
      default: w_occ_n = r_occ;
    endcase
    // A slot committed this cycle is not yet in r_slot_len, so bypass it
    if (w_occ_n == {OCC_W{1'b0}}) begin
      w_head_len = {WA_W{1'b0}};
    end else if (w_keep && (w_rd_ptr_n == r_wr_ptr)) begin
      w_head_len = w_new_len;
    end else begin
      w_head_len = r_slot_len[w_rd_ptr_n];
    end
  end

  // Byte address a goes to lane 3-a[1:0] so byte 0 sits in bits [31:24]
  always_comb begin
    w_lane    = 2'd3 - r_rxa_d[1:0];
    w_be      = 4'b0001 << w_lane;
    w_wr_addr = {r_wr_ptr, r_rxa_d[ADDR_W-1:2]};
    w_rd_addr = {r_rd_ptr, read_addr};
  end

  // Copy FSM: walk rxa over the frame, then hold copydone until upstream lets go
  always_ff @(posedge mac_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_rxa      <= {ADDR_W{1'b0}};
      r_rxa_d    <= {ADDR_W{1'b0}};
      r_wr_vld   <= 1'b0;
      r_copydone <= 1'b0;
      r_pkt_len  <= {LEN_W{1'b0}};
    end else begin
      r_rxa_d  <= r_rxa;
      r_wr_vld <= (r_state == ST_COPY);
      case (r_state)
        ST_IDLE: begin
          r_rxa      <= {ADDR_W{1'b0}};
          r_copydone <= 1'b0;
          if (incoming_ready && !r_busy) begin
            r_state <= ST_COPY;
          end
        end
        ST_COPY: begin
          if (r_rxa == rxl) begin
            r_state    <= ST_DONE;
            r_copydone <= 1'b1;
            r_pkt_len  <= LEN_W'(pkt_len(int'(rxl), HDR_BYTES, HDR_WORDS));
          end else begin
            r_rxa <= r_rxa + ADDR_W'(1);
          end
        end
        ST_DONE: begin
          if (!incoming_ready) begin
            r_state    <= ST_IDLE;
            r_copydone <= 1'b0;
            r_rxa      <= {ADDR_W{1'b0}};
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_rxa      <= {ADDR_W{1'b0}};
          r_copydone <= 1'b0;
        end
      endcase
    end
  end

  // Ring pointers, occupancy flags, head length and runt counter
  always_ff @(posedge mac_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_occ    <= {OCC_W{1'b0}};
      r_avail  <= 1'b0;
      r_busy   <= 1'b0;
      r_len    <= {WA_W{1'b0}};
      r_drop   <= {CNT_W{1'b0}};
    end else begin
      r_wr_ptr <= w_wr_ptr_n;
      r_rd_ptr <= w_rd_ptr_n;
      r_occ    <= w_occ_n;
      r_avail  <= (w_occ_n != {OCC_W{1'b0}});
      r_busy   <= (w_occ_n == OCC_W'(NSLOTS));
      r_len    <= w_head_len;
      if (w_drop && (r_drop != {CNT_W{1'b1}})) begin
        r_drop <= r_drop + CNT_W'(1);
      end
    end
  end

  // Per-slot payload lengths, written at commit
  always_ff @(posedge mac_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSLOTS; i++) begin
        r_slot_len[i] <= {WA_W{1'b0}};
      end
    end else if (w_keep) begin
      r_slot_len[r_wr_ptr] <= w_new_len;
    end
  end

  sub_packetreq_ram #(
    .AW (PTR_W + WA_W)
  ) u_ram (
    .i_clk   (mac_clk),
    .i_rst_n (reset_n),
    .i_we    (r_wr_vld),
    .i_be    (w_be),
    .i_waddr (w_wr_addr),
    .i_wdata ({4{rxd}}),
    .i_raddr (w_rd_addr),
    .o_rdata (read_data)
  );

  assign rxa          = r_rxa;
  assign copydone     = r_copydone;
  assign packet_avail = r_avail;
  assign busy         = r_busy;
  assign len          = r_len;
  assign occupancy    = r_occ;
  assign drop_count   = r_drop;

endmodule

// File: tb/tb_sub_packetreq_ring.sv
// Directed bench for sub_packetreq_ring: frame copy, ring full/hold, runt drop,
// simultaneous commit/release, mid-copy reset and pointer wrap.
module tb_sub_packetreq_ring;

  logic        mac_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        incoming_ready = 1'b0;
  logic        done_with_packet = 1'b0;
  logic [10:0] rxl = 11'd0;
  logic [10:0] rxa;
  logic [7:0]  rxd;
  logic        copydone, packet_avail, busy;
  logic [8:0]  read_addr = 9'd0;
  logic [8:0]  len;
  logic [31:0] read_data;
  logic [2:0]  occupancy;
  logic [15:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rx_mem [2048];

  always #5 mac_clk = ~mac_clk;

  // RX side: byte at rxa appears one cycle later
  always @(posedge mac_clk) rxd <= rx_mem[rxa];

  sub_packetreq_ring dut (
    .mac_clk(mac_clk), .reset_n(reset_n), .incoming_ready(incoming_ready),
    .rxl(rxl), .rxa(rxa), .rxd(rxd), .copydone(copydone),
    .done_with_packet(done_with_packet), .packet_avail(packet_avail), .busy(busy),
    .read_addr(read_addr), .read_data(read_data), .len(len),
    .occupancy(occupancy), .drop_count(drop_count)
  );

  function automatic logic [7:0] bval(input int seed, input int i);
    return 8'((seed * 53 + i * 11 + 7) % 256);
  endfunction

  function automatic logic [31:0] wexp(input int seed, input int w);
    return {bval(seed, 4*w), bval(seed, 4*w+1), bval(seed, 4*w+2), bval(seed, 4*w+3)};
  endfunction

  task automatic do_reset;
    @(negedge mac_clk);
    reset_n = 1'b0; incoming_ready = 1'b0; done_with_packet = 1'b0;
    repeat (2) @(negedge mac_clk);
    reset_n = 1'b1;
    @(negedge mac_clk);
  endtask

  task automatic start_frame(input int rxl_v, input int seed);
    for (int i = 0; i <= rxl_v; i++) rx_mem[i] = bval(seed, i);
    rxl = 11'(rxl_v);
    incoming_ready = 1'b1;
  endtask

  task automatic wait_copydone(output int cycles);
    cycles = 0;
    while (copydone !== 1'b1 && cycles < 4000) begin
      @(negedge mac_clk);
      cycles++;
    end
    if (copydone !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL copydone_timeout: copydone=%b after %0d cycles, want 1", copydone, cycles);
    end
  endtask

  task automatic finish_frame(input logic rel);
    incoming_ready = 1'b0;
    done_with_packet = rel;
    @(negedge mac_clk);
    done_with_packet = 1'b0;
  endtask

  task automatic send_frame(input int rxl_v, input int seed, input logic rel, output int cycles);
    start_frame(rxl_v, seed);
    wait_copydone(cycles);
    finish_frame(rel);
  endtask

  task automatic release_pkt;
    done_with_packet = 1'b1;
    @(negedge mac_clk);
    done_with_packet = 1'b0;
  endtask

  task automatic read_word(input int a, output logic [31:0] d);
    read_addr = 9'(a);
    @(negedge mac_clk);
    d = read_data;
  endtask

  task automatic test_reset;
    @(negedge mac_clk);
    n_cmp++;
    if ({rxa, copydone, packet_avail, busy, len, occupancy, drop_count, read_data} !== 74'd0) begin
      n_err++;
      $display("FAIL reset_outputs: rxa=%0d cd=%b av=%b busy=%b len=%0d occ=%0d drop=%0d rd=%h, want all 0",
               rxa, copydone, packet_avail, busy, len, occupancy, drop_count, read_data);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge mac_clk);
    n_cmp++;
    if ({rxa, copydone, packet_avail, busy, len, occupancy, drop_count} !== 42'd0) begin
      n_err++;
      $display("FAIL reset_idle: rxa=%0d cd=%b av=%b busy=%b len=%0d occ=%0d drop=%0d, want all 0",
               rxa, copydone, packet_avail, busy, len, occupancy, drop_count);
    end
  endtask

  task automatic test_single_frame;
    int cyc;
    logic [31:0] d;
    do_reset();
    start_frame(77, 1);
    wait_copydone(cyc);
    n_cmp++; if (cyc !== 79) begin n_err++; $display("FAIL t1_latency: got %0d want 79", cyc); end
    finish_frame(1'b0);
    n_cmp++; if (packet_avail !== 1'b1) begin n_err++; $display("FAIL t1_avail: got %b want 1", packet_avail); end
    n_cmp++; if (len !== 9'd9) begin n_err++; $display("FAIL t1_len: got %0d want 9", len); end
    n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL t1_occ: got %0d want 1", occupancy); end
    n_cmp++; if (copydone !== 1'b0) begin n_err++; $display("FAIL t1_copydone_low: got %b want 0", copydone); end
    read_word(0, d);
    n_cmp++; if (d !== wexp(1, 0)) begin n_err++; $display("FAIL t1_word0: got %h want %h", d, wexp(1, 0)); end
    read_word(5, d);
    n_cmp++; if (d !== wexp(1, 5)) begin n_err++; $display("FAIL t1_word5: got %h want %h", d, wexp(1, 5)); end
  endtask

  task automatic test_release_empty;
    int cyc;
    logic [31:0] d;
    do_reset();
    release_pkt();
    n_cmp++;
    if ({occupancy, packet_avail, len} !== 13'd0) begin
      n_err++; $display("FAIL rel_empty: occ=%0d av=%b len=%0d, want 0", occupancy, packet_avail, len);
    end
    send_frame(77, 40, 1'b0, cyc);
    n_cmp++; if (len !== 9'd9) begin n_err++; $display("FAIL rel_empty_len: got %0d want 9", len); end
    read_word(0, d);
    n_cmp++; if (d !== wexp(40, 0)) begin n_err++; $display("FAIL rel_empty_word0: got %h want %h", d, wexp(40, 0)); end
  endtask

  task automatic test_full;
    int cyc;
    logic [31:0] d;
    do_reset();
    send_frame(77, 10, 1'b0, cyc);
    send_frame(81, 11, 1'b0, cyc);
    send_frame(89, 12, 1'b0, cyc);
    send_frame(101, 13, 1'b0, cyc);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy: got %b want 1", busy); end
    n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL full_occ: got %0d want 4", occupancy); end
    n_cmp++; if (len !== 9'd9) begin n_err++; $display("FAIL full_len: got %0d want 9", len); end
    start_frame(61, 14);
    repeat (10) @(negedge mac_clk);
    n_cmp++;
    if ({rxa, copydone} !== 12'd0) begin
      n_err++; $display("FAIL full_hold: rxa=%0d cd=%b, want 0/0", rxa, copydone);
    end
    release_pkt();
    n_cmp++;
    if ({occupancy, busy, len} !== {3'd3, 1'b0, 9'd10}) begin
      n_err++; $display("FAIL full_release: occ=%0d busy=%b len=%0d, want 3/0/10", occupancy, busy, len);
    end
    wait_copydone(cyc);
    finish_frame(1'b0);
    n_cmp++;
    if ({occupancy, busy} !== {3'd4, 1'b1}) begin
      n_err++; $display("FAIL full_fifth: occ=%0d busy=%b, want 4/1", occupancy, busy);
    end
    release_pkt();
    n_cmp++; if (len !== 9'd12) begin n_err++; $display("FAIL full_len2: got %0d want 12", len); end
    release_pkt();
    n_cmp++; if (len !== 9'd15) begin n_err++; $display("FAIL full_len3: got %0d want 15", len); end
    release_pkt();
    n_cmp++; if (len !== 9'd5) begin n_err++; $display("FAIL full_len4: got %0d want 5", len); end
    read_word(2, d);
    n_cmp++; if (d !== wexp(14, 2)) begin n_err++; $display("FAIL full_fifth_word2: got %h want %h", d, wexp(14, 2)); end
  endtask

  task automatic test_runt;
    int cyc;
    logic [31:0] d;
    do_reset();
    send_frame(77, 20, 1'b0, cyc);
    send_frame(40, 21, 1'b0, cyc);
    n_cmp++; if (cyc !== 42) begin n_err++; $display("FAIL runt_latency: got %0d want 42", cyc); end
    n_cmp++; if (drop_count !== 16'd1) begin n_err++; $display("FAIL runt_drop: got %0d want 1", drop_count); end
    n_cmp++;
    if ({occupancy, len, rxa} !== {3'd1, 9'd9, 11'd0}) begin
      n_err++; $display("FAIL runt_state: occ=%0d len=%0d rxa=%0d, want 1/9/0", occupancy, len, rxa);
    end
    send_frame(85, 22, 1'b0, cyc);
    release_pkt();
    n_cmp++; if (len !== 9'd11) begin n_err++; $display("FAIL runt_next_len: got %0d want 11", len); end
    read_word(0, d);
    n_cmp++; if (d !== wexp(22, 0)) begin n_err++; $display("FAIL runt_next_word0: got %h want %h", d, wexp(22, 0)); end
  endtask

  task automatic test_commit_release;
    int cyc;
    logic [31:0] d;
    do_reset();
    send_frame(77, 30, 1'b0, cyc);
    send_frame(81, 31, 1'b0, cyc);
    send_frame(89, 32, 1'b1, cyc);
    n_cmp++; if (occupancy !== 3'd2) begin n_err++; $display("FAIL cr_occ: got %0d want 2", occupancy); end
    n_cmp++; if (len !== 9'd10) begin n_err++; $display("FAIL cr_len: got %0d want 10", len); end
    read_word(0, d);
    n_cmp++; if (d !== wexp(31, 0)) begin n_err++; $display("FAIL cr_word0: got %h want %h", d, wexp(31, 0)); end
    release_pkt();
    n_cmp++; if (len !== 9'd12) begin n_err++; $display("FAIL cr_len2: got %0d want 12", len); end
    read_word(1, d);
    n_cmp++; if (d !== wexp(32, 1)) begin n_err++; $display("FAIL cr_word1: got %h want %h", d, wexp(32, 1)); end
  endtask

  task automatic test_reset_mid_copy;
    int cyc;
    int cnt;
    logic [31:0] d;
    do_reset();
    send_frame(77, 50, 1'b0, cyc);
    send_frame(40, 51, 1'b0, cyc);
    start_frame(77, 52);
    cnt = 0;
    while (rxa !== 11'd20 && cnt < 200) begin
      @(negedge mac_clk);
      cnt++;
    end
    n_cmp++; if (rxa !== 11'd20) begin n_err++; $display("FAIL mid_reach_rxa20: got %0d want 20", rxa); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({rxa, copydone, packet_avail, busy, len, occupancy, drop_count, read_data} !== 74'd0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: rxa=%0d cd=%b av=%b busy=%b len=%0d occ=%0d drop=%0d rd=%h, want all 0",
               rxa, copydone, packet_avail, busy, len, occupancy, drop_count, read_data);
    end
    incoming_ready = 1'b0;
    repeat (2) @(negedge mac_clk);
    reset_n = 1'b1;
    @(negedge mac_clk);
    send_frame(93, 53, 1'b0, cyc);
    n_cmp++; if (cyc !== 95) begin n_err++; $display("FAIL mid_latency: got %0d want 95", cyc); end
    n_cmp++;
    if ({occupancy, len} !== {3'd1, 9'd13}) begin
      n_err++; $display("FAIL mid_new_frame: occ=%0d len=%0d, want 1/13", occupancy, len);
    end
    read_word(0, d);
    n_cmp++; if (d !== wexp(53, 0)) begin n_err++; $display("FAIL mid_word0: got %h want %h", d, wexp(53, 0)); end
  endtask

  task automatic test_wrap;
    int cyc;
    logic [31:0] d;
    int wrap_rxl [9] = '{61, 65, 70, 77, 81, 89, 93, 101, 110};
    int wrap_len [9] = '{5, 6, 7, 9, 10, 12, 13, 15, 17};
    do_reset();
    send_frame(wrap_rxl[0], 60, 1'b0, cyc);
    for (int k = 1; k <= 8; k++) begin
      send_frame(wrap_rxl[k], 60 + k, 1'b0, cyc);
      n_cmp++;
      if (len !== 9'(wrap_len[k-1])) begin
        n_err++; $display("FAIL wrap_len[%0d]: got %0d want %0d", k-1, len, wrap_len[k-1]);
      end
      read_word(0, d);
      n_cmp++;
      if (d !== wexp(59 + k, 0)) begin
        n_err++; $display("FAIL wrap_word0[%0d]: got %h want %h", k-1, d, wexp(59 + k, 0));
      end
      read_word(3, d);
      n_cmp++;
      if (d !== wexp(59 + k, 3)) begin
        n_err++; $display("FAIL wrap_word3[%0d]: got %h want %h", k-1, d, wexp(59 + k, 3));
      end
      release_pkt();
    end
    n_cmp++; if (len !== 9'd17) begin n_err++; $display("FAIL wrap_len[8]: got %0d want 17", len); end
    read_word(0, d);
    n_cmp++; if (d !== wexp(68, 0)) begin n_err++; $display("FAIL wrap_word0[8]: got %h want %h", d, wexp(68, 0)); end
    release_pkt();
    n_cmp++;
    if ({occupancy, packet_avail, len} !== 13'd0) begin
      n_err++; $display("FAIL wrap_empty: occ=%0d av=%b len=%0d, want 0", occupancy, packet_avail, len);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_release_empty();
    test_full();
    test_runt();
    test_commit_release();
    test_reset_mid_copy();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
